// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, memory-state and arbiter-state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
endpackage

// File: rtl/arb_timer.sv
// arb_timer: counts enabled cycles and flags the TIMEOUT-th one
module arb_timer #(
  parameter int TIMEOUT = 31
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] count;
  always_ff @(posedge CLK or posedge RST)
    if (RST) count <= '0;
    else count <= clear ? '0 : enable ? count + W'(1) : count;
  assign expired = enable && count == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction and data requesters.
// Define MEM_ARBITER_RR_EN for round-robin on contention; otherwise data has fixed priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT = 31,
  parameter word_t BADWORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);
  arb_state_t state;
  word_t addr_r, store_r, rdata;
  logic wen_r, dreq, pick_d, gnt, req_g, acc, expired, done, fin;
  assign dreq = dREN | dWEN;
`ifdef MEM_ARBITER_RR_EN
  logic last_d;
  assign pick_d = dreq && !(iREN && last_d);
  always_ff @(posedge CLK or posedge RST)
    if (RST) last_d <= 1'b0;
    else if (done) last_d <= state == GNT_D;
`else
  assign pick_d = dreq;
`endif
  assign gnt = state != IDLE;
  assign req_g = state == GNT_D ? dreq : state == GNT_I && iREN;
  assign acc = ramstate == ACCESS;
  assign done = req_g && (acc || expired);
  // a grant ends on completion, timeout, or the owner withdrawing its request
  assign fin = gnt && (!req_g || acc || expired);
  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK(CLK),
    .RST(RST),
    .clear(!gnt || fin),
    .enable(gnt && !acc),
    .expired(expired)
  );
  assign rdata = expired ? BADWORD : wen_r ? '0 : ramload;
  assign iload = done && state == GNT_I ? rdata : '0;
  assign dload = done && state == GNT_D ? rdata : '0;
  assign iwait = iREN && !(done && state == GNT_I);
  assign dwait = dreq && !(done && state == GNT_D);
  assign ramREN = gnt && !wen_r;
  assign ramWEN = gnt && wen_r;
  assign ramaddr = addr_r;
  assign ramstore = store_r;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      addr_r <= '0;
      store_r <= '0;
      wen_r <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= err || (done && expired);
      if (!gnt) begin
        state <= pick_d ? GNT_D : iREN ? GNT_I : IDLE;
        addr_r <= pick_d ? daddr : iaddr;
        store_r <= pick_d ? dstore : '0;
        wen_r <= pick_d && dWEN;
      end else if (fin) state <= IDLE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboarded random and directed checks for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam word_t BAD = 32'hBAD1BAD1;
  logic clk = 0, rst = 1;
  logic iREN = 0, dREN = 0, dWEN = 0;
  word_t iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  ramstate_t ramstate = FREE;
  logic iwait, dwait, ramREN, ramWEN, err;
  word_t iload, dload, ramaddr, ramstore;
  int tests = 0, failed = 0;
  logic [32:0] iq[$], dq[$];
  int lat_sel = -1;
  logic fix_en = 0;
  word_t fix_val = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .CLK(clk), .RST(rst),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );
  function automatic word_t f(word_t a);
    return a ^ 32'h5EED1234;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s: got %h, want %h", n, a, e);
    end
  endtask
  // memory model: answers ACCESS after lat cycles of a grant, BUSY/ERROR before
  int busy = 0, cnt = 0, lat = 0;
  always @(posedge clk) begin
    #2;
    if (rst || !(ramREN || ramWEN)) begin
      busy = 0;
      ramstate = FREE;
    end else begin
      if (busy == 0) begin
        busy = 1;
        cnt = 0;
        lat = lat_sel < 0 ? int'($urandom_range(0, 3)) : lat_sel;
      end
      ramstate = cnt == lat ? ACCESS : $urandom_range(0, 1) ? ERROR : BUSY;
      cnt++;
    end
    ramload = fix_en ? fix_val : f(ramaddr);
  end
  // monitor: completions against the scoreboard, grant ownership, stability, bubble
  logic p_i = 0, p_d = 0, p_wen = 0, p_en = 0, p_done = 0, p_rwen = 0, last_d = 0;
  word_t p_ia = 0, p_da = 0, p_ds = 0, p_ra = 0, p_rs = 0;
  always @(negedge clk) begin
    logic en, ic, dc, expd;
    logic [32:0] e;
    en = ramREN || ramWEN;
    ic = iREN && !iwait;
    dc = (dREN || dWEN) && !dwait;
    if (rst) last_d = 0;
    else begin
      if (ic) begin
        chk("iq_pending", iq.size() != 0, 1);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          chk("iload", iload, e[31:0]);
        end
      end else chk("iload_idle", iload, 0);
      if (dc) begin
        chk("dq_pending", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          if (e[32]) chk("dload", dload, e[31:0]);
        end
      end else chk("dload_idle", dload, 0);
      chk("ram_both_en", ramREN && ramWEN, 0);
      if (p_done) chk("bubble", en, 0);
      if (en && !p_en) begin
`ifdef MEM_ARBITER_RR_EN
        expd = p_d && !(p_i && last_d);
`else
        expd = p_d;
`endif
        chk("grant_req", p_i || p_d, 1);
        chk("grant_addr", ramaddr, expd ? p_da : p_ia);
        chk("grant_wen", ramWEN, expd && p_wen);
        if (expd && p_wen) chk("grant_store", ramstore, p_ds);
      end
      if (en && p_en) begin
        chk("stable_addr", ramaddr, p_ra);
        chk("stable_wen", ramWEN, p_rwen);
        chk("stable_store", ramstore, p_rs);
      end
      if (en && ic) last_d = 0;
      if (en && dc) last_d = 1;
    end
    p_done = !rst && en && (ic || dc);
    p_en = en;
    p_i = iREN;
    p_d = dREN || dWEN;
    p_wen = dWEN;
    p_ia = iaddr;
    p_da = daddr;
    p_ds = dstore;
    p_ra = ramaddr;
    p_rs = ramstore;
    p_rwen = ramWEN;
  end
  task automatic drv();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_i();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (iwait && t < 200);
    chk("i_done_in_time", iwait, 0);
  endtask
  task automatic wait_d();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (dwait && t < 200);
    chk("d_done_in_time", dwait, 0);
  endtask
  task automatic imaster(int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      drv();
      iREN = 1;
      iaddr = $urandom;
      iq.push_back({1'b1, f(iaddr)});
      wait_i();
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drv();
        iREN = 0;
        repeat (gap) @(posedge clk);
      end
    end
    drv();
    iREN = 0;
  endtask
  task automatic dmaster(int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      drv();
      dREN = 1;
      dWEN = $urandom_range(0, 1);
      daddr = $urandom;
      dstore = $urandom;
      dq.push_back(dWEN ? 33'd0 : {1'b1, f(daddr)});
      wait_d();
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drv();
        dREN = 0;
        dWEN = 0;
        repeat (gap) @(posedge clk);
      end
    end
    drv();
    dREN = 0;
    dWEN = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: time budget exceeded");
    $fatal(1);
  end
  initial begin
    int n, t;
    @(negedge clk);
    #1;
    iREN = 1;
    dWEN = 1;
    daddr = 32'h1234;
    @(negedge clk);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_err", err, 0);
    iREN = 0;
    dWEN = 0;
    @(negedge clk);
    #1 rst = 0;
    // instruction read completing on the third grant cycle
    lat_sel = 2;
    fix_en = 1;
    fix_val = 32'h1234;
    drv();
    iREN = 1;
    iaddr = 32'h40;
    iq.push_back({1'b1, 32'h1234});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rd_iwait", iwait, k != 3);
      chk("rd_ramREN", ramREN, k > 0);
    end
    drv();
    iREN = 0;
    fix_en = 0;
    @(negedge clk);
    chk("rd_after_idle", ramREN, 0);
    // simultaneous requests: data first, bubble, then instruction
    lat_sel = 0;
    drv();
    iREN = 1;
    iaddr = 32'h300;
    dREN = 1;
    daddr = 32'h400;
    iq.push_back({1'b1, f(32'h300)});
    dq.push_back({1'b1, f(32'h400)});
    @(negedge clk);
    @(negedge clk);
    chk("both_first_addr", ramaddr, 32'h400);
    chk("both_first_dwait", dwait, 0);
    chk("both_first_iwait", iwait, 1);
    drv();
    dREN = 0;
    @(negedge clk);
    chk("both_bubble", ramREN, 0);
    chk("both_bubble_iwait", iwait, 1);
    @(negedge clk);
    chk("both_second_addr", ramaddr, 32'h300);
    chk("both_second_iwait", iwait, 0);
    drv();
    iREN = 0;
    // write with both enables high
    lat_sel = 2;
    drv();
    dREN = 1;
    dWEN = 1;
    daddr = 32'h80;
    dstore = 32'hCAFE;
    dq.push_back(33'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_dwait", dwait, k != 3);
      if (k > 0) begin
        chk("wr_ramWEN", ramWEN, 1);
        chk("wr_ramREN", ramREN, 0);
        chk("wr_ramstore", ramstore, 32'hCAFE);
        chk("wr_ramaddr", ramaddr, 32'h80);
      end
    end
    drv();
    dREN = 0;
    dWEN = 0;
    // random contention phase
    lat_sel = -1;
    fork
      imaster(40);
      dmaster(40);
    join
    repeat (3) @(negedge clk);
    // abort mid-grant, then full timeout with a fresh timer
    lat_sel = 1000;
    drv();
    dREN = 1;
    dWEN = 0;
    daddr = 32'h100;
    repeat (10) @(negedge clk);
    drv();
    dREN = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_idle", ramREN, 0);
    chk("abort_err", err, 0);
    drv();
    dREN = 1;
    daddr = 32'h104;
    dq.push_back({1'b1, BAD});
    n = 0;
    t = 0;
    do begin
      @(negedge clk);
      if (ramREN) n++;
      t++;
    end while (dwait && t < 100);
    chk("timeout_cycles", n, 31);
    drv();
    dREN = 0;
    @(negedge clk);
    chk("timeout_err", err, 1);
    chk("timeout_idle", ramREN, 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    // reset in the middle of a data grant
    drv();
    dREN = 1;
    daddr = 32'h200;
    repeat (3) @(negedge clk);
    chk("pre_rst_grant", ramREN, 1);
    #1 rst = 1;
    #1;
    chk("midrst_ramREN", ramREN, 0);
    chk("midrst_ramWEN", ramWEN, 0);
    chk("midrst_dwait", dwait, 1);
    chk("midrst_dload", dload, 0);
    chk("midrst_err", err, 0);
    chk("midrst_ramaddr", ramaddr, 0);
    lat_sel = 1;
    @(negedge clk);
    dq.push_back({1'b1, f(32'h200)});
    #1 rst = 0;
    wait_d();
    chk("regrant_addr", ramaddr, 32'h200);
    drv();
    dREN = 0;
    repeat (3) @(negedge clk);
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 31: wait cycles allowed per grant before abort.
REQ-002 Parameter BADWORD, default 32'hBAD1BAD1: load value returned on timeout.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  system clock, rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 iREN  in  1; iaddr  in  32  instruction read request and address.
REQ-007 iwait  out  1; iload  out  32  instruction stall and returned word.
REQ-008 dREN  in  1; dWEN  in  1; daddr  in  32; dstore  in  32  data request, address, write data.
REQ-009 dwait  out  1; dload  out  32  data stall and returned word.
REQ-010 ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32  memory-side request.
REQ-011 ramload  in  32; ramstate  in  ramstate_t (FREE/BUSY/ACCESS/ERROR)  memory-side response.
REQ-012 err  out  1  sticky timeout flag.

Function
REQ-013 FSM states: IDLE, GNT_I, GNT_D.
REQ-014 IDLE: ramREN=ramWEN=0; latch address, store data and op of the winning requester; next state GNT_I or GNT_D; no request -> stay IDLE.
REQ-015 Arbitration with both pending: data wins (default build).
REQ-016 dREN and dWEN both high: treated as write; ramREN=0.
REQ-017 GNT_x: drive ramREN/ramWEN/ramaddr/ramstore from latched registers only; values stable for the whole grant.
REQ-018 Completion: ramstate==ACCESS in GNT_x -> granted wait low that same cycle, load=ramload (reads), next state IDLE.
REQ-019 Mandatory IDLE bubble between grants; ram enables low for one cycle; min latency request->wait low = 2 cycles.
REQ-020 wait = request && !(completion for that port); non-granted requester's wait stays high.
REQ-021 A request still held the cycle after completion is a new transaction.
REQ-022 Granted requester drops its request mid-grant -> abort, IDLE next cycle, no wait pulse, timer cleared.
REQ-023 Timer counts GNT cycles without ACCESS (BUSY or ERROR); reaching TIMEOUT -> wait low, load=BADWORD, err set, IDLE next.
REQ-024 Load outputs = 0 when not completing.

Reset
REQ-025 RST high: state IDLE, timer 0, latched addr/store 0, err 0, last-grant = instruction.
REQ-026 While RST high: ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0; wait = corresponding request.
REQ-027 Reset mid-grant: grant discarded; no completion reported.

Configuration
REQ-028 Macro MEM_ARBITER_RR_EN defined: round-robin on contention; opposite of last completed grant wins.
REQ-029 Macro absent: fixed data priority; last-grant register not synthesized.

Structure
REQ-030 arb_state_t (IDLE/GNT_I/GNT_D) added to cpu_types_pkg; word_t and ramstate_t reused from it.
REQ-031 Sub-module arb_timer: clear, enable, TIMEOUT parameter, expired output.

Verification
REQ-032 iREN=1 iaddr=0x40; ramstate ACCESS at 3rd GNT_I cycle, ramload=0x1234 -> iwait low that cycle, iload=0x1234, then IDLE with ramREN=0.
REQ-033 iREN and dREN same cycle, default build -> GNT_D first, IDLE bubble, then GNT_I; ramaddr never changes within a grant.
REQ-034 dREN=dWEN=1 daddr=0x80 dstore=0xCAFE -> ramWEN=1, ramREN=0, ramstore=0xCAFE until ACCESS.
REQ-035 ramstate held BUSY, TIMEOUT=31 -> dwait low on 31st GNT cycle, dload=0xBAD1BAD1, err=1 until reset.
REQ-036 RST pulsed during GNT_D -> ram enables low immediately; after release, held request regranted from IDLE.
REQ-037 MEM_ARBITER_RR_EN defined, both requests held continuously -> grants alternate I,D,I,D after first D.
